iic_dsmod_ctrl: RTL and testbench
=================================

IIC_DSMOD_CTRL -- requirements
Module: iic_dsmod_ctrl

Interface
REQ-001 SHALL have parameter BW, default 16: sample width, UINT, midscale 2^(BW-1).
REQ-002 SHALL have parameter DEPTH, default 4: sample FIFO depth, power of two, minimum 2.
REQ-003 SHALL have parameter RAMP_SAMPLES, default 8: number of dsm_rd_i pulses per scale step.
REQ-004 SHALL use one clock and a reset that is asynchronous and active-low, with these ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  level; 1 = play, 0 = stop.
- mode_i  in  1  modulator order; 0 = 1st, 1 = 2nd.
- osr_i  in  2  OSR code; 0/1/2/3 = 32/64/128/256.
- scale_i  in  4  target attenuation; 0 = 0 dB, 15 = off.
- clr_i  in  1  clears underrun_o.
- s_data_i  in  BW  input sample.
- s_valid_i  in  1  sample valid.
- s_ready_o  out  1  FIFO can accept.
- dsm_data_o  out  BW  sample to modulator.
- dsm_rd_i  in  1  modulator fetch strobe, one cycle wide.
- dsm_rst_n_o  out  1  modulator synchronous reset, active-low.
- dsm_mode_o  out  1  latched order.
- dsm_osr_o  out  2  latched OSR code.
- dsm_scale_o  out  4  current ramped scale.
- busy_o  out  1  state is not IDLE.
- underrun_o  out  1  sticky underrun flag.
- fill_o  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-005 SHALL accept a sample when s_valid_i and s_ready_o are both 1; s_ready_o SHALL equal !full in every state.
REQ-006 SHALL, on a dsm_rd_i cycle in a non-IDLE state with a non-empty FIFO, register the FIFO head into dsm_data_o (visible the next cycle) and pop it.
REQ-007 SHALL, on a dsm_rd_i cycle with an empty FIFO in a non-IDLE state, load DATA_MID into dsm_data_o and set underrun_o.
REQ-008 SHALL ignore dsm_rd_i in IDLE.
REQ-009 SHALL, when a push and a pop occur in the same cycle, update both and leave fill_o unchanged; a push to a full FIFO cannot occur.
REQ-010 SHALL clear underrun_o on clr_i, with a simultaneous set taking priority.
REQ-011 SHALL implement states IDLE, RAMP_UP, RUN and RAMP_DOWN.
REQ-012 IDLE: dsm_rst_n_o=0, dsm_scale_o=15, dsm_data_o=DATA_MID; on enable_i=1, latch mode_i and osr_i into dsm_mode_o/dsm_osr_o, clear the ramp counter, go to RAMP_UP.
REQ-013 RAMP_UP: dsm_rst_n_o=1; each time the counter reaches RAMP_SAMPLES dsm_rd_i pulses, wrap it to 0 and decrement dsm_scale_o by 1 if it exceeds scale_i; go to RUN once dsm_scale_o equals scale_i.
REQ-014 RUN: on each RAMP_SAMPLES boundary, step dsm_scale_o by ±1 toward scale_i, so no step is ever larger than 1.
REQ-015 On enable_i=0 in RAMP_UP or RUN, SHALL go to RAMP_DOWN without resetting the ramp counter.
REQ-016 RAMP_DOWN: increment dsm_scale_o by 1 per boundary; when it reaches 15, go to IDLE and flush the FIFO (fill_o becomes 0 the next cycle).
REQ-017 On enable_i=1 in RAMP_DOWN, SHALL return to RAMP_UP from the current dsm_scale_o.
REQ-018 SHALL ignore mode_i and osr_i changes outside IDLE.
REQ-019 SHALL, if scale_i is 15, have RAMP_UP go directly to RUN with dsm_scale_o held at 15.

Reset
REQ-020 SHALL, while rst_n_i=0, asynchronously force: state IDLE, FIFO empty, dsm_data_o=DATA_MID, dsm_rst_n_o=0, dsm_scale_o=15, dsm_mode_o=0, dsm_osr_o=0, underrun_o=0, busy_o=0, s_ready_o=0, ramp counter 0.
REQ-021 SHALL assert s_ready_o=1 on the first clock after reset release.
REQ-022 SHALL, on reset mid-operation, discard all FIFO contents and resume in IDLE.

Structure
REQ-023 SHALL take DATA_MID, SCALE_OFF (15), the OSR codes, MODE codes and the state encoding from shared package iic_dsmod_pkg, which iic_dsmod also uses.
REQ-024 SHALL instantiate the FIFO as sub-module iic_sync_fifo (parameters BW, DEPTH; push, pop, flush, full, empty, count).
REQ-025 SHALL be integrated by connecting dsm_rd_i to data_rd_o, dsm_data_o to data_i, and dsm_rst_n_o to rst_n_i of the modulator.

Verification
REQ-026 Start-up ramp: prefill 4 samples, scale_i=2, enable_i=1, pulse dsm_rd_i every 32 clk -> dsm_scale_o 15..2 in 13 steps of 8 pulses each, then RUN.
REQ-027 Underrun: in RUN with the FIFO empty, pulse dsm_rd_i -> dsm_data_o=0x8000, underrun_o=1 until clr_i.
REQ-028 Simultaneous push/pop at fill 2 -> fill stays 2, data order preserved (0x1234 then 0x5678).
REQ-029 Stop: enable_i=0 at dsm_scale_o=5 -> 10 steps to 15, IDLE, dsm_rst_n_o=0, fill_o=0.
REQ-030 Re-enable during RAMP_DOWN at scale 9 with scale_i=0 -> ramps 9..0, never jumps.
REQ-031 Async reset asserted mid-RUN -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/iic_dsmod_pkg.sv
// Shared constants for the delta-sigma modulator and its front-end controller.
// Holds the mid-scale sample value, the attenuation "off" code, the OSR and
// modulator-order codes, and the controller state encoding. No ports.
package iic_dsmod_pkg;

    // Attenuation code that fully mutes the modulator output.
    localparam logic [3:0] SCALE_OFF = 4'd15;

    // Oversampling-ratio codes.
    localparam logic [1:0] OSR_32  = 2'd0;
    localparam logic [1:0] OSR_64  = 2'd1;
    localparam logic [1:0] OSR_128 = 2'd2;
    localparam logic [1:0] OSR_256 = 2'd3;

    // Modulator order codes.
    localparam logic MODE_1ST = 1'b0;
    localparam logic MODE_2ND = 1'b1;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    // Mid-scale value of an unsigned sample of width bw (2^(bw-1)).
    // Callers truncate the result to their own sample width.
    function automatic logic [63:0] data_mid_of(input int bw);
        return 64'd1 << (bw - 1);
    endfunction

    // One attenuation step toward the target, never more than 1.
    function automatic logic [3:0] scale_toward(input logic [3:0] cur, input logic [3:0] tgt);
        if (cur > tgt) begin
            return cur - 4'd1;
        end else if (cur < tgt) begin
            return cur + 4'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/iic_dsmod_ctrl_if.sv
// Bundle of the sample stream and modulator fetch signals around the
// delta-sigma controller.
//   s_data / s_valid / s_ready : sample stream into the controller FIFO
//   dsm_data / dsm_rd / dsm_rst_n : modulator side (fetch strobe in, sample
//                                    and modulator reset out)
// master = producer/modulator side, slave = controller side.
interface iic_dsmod_ctrl_if #(parameter int BW = 16) ();

    logic [BW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] dsm_data;
    logic          dsm_rd;
    logic          dsm_rst_n;

    modport master (
        output s_data, s_valid, dsm_rd,
        input  s_ready, dsm_data, dsm_rst_n
    );

    modport slave (
        input  s_data, s_valid, dsm_rd,
        output s_ready, dsm_data, dsm_rst_n
    );

endinterface

// File: rtl/iic_sync_fifo.sv
// Single-clock sample FIFO with synchronous flush and async active-low reset.
// Ports:
//   clk_i, rst_n_i    clock and asynchronous active-low reset
//   push_i / data_i   write request and write data (ignored when full)
//   pop_i / data_o    read request and head-of-queue data (ignored when empty)
//   flush_i           discard all contents; wins over push and pop
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
module iic_sync_fifo #(
    parameter int BW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [BW-1:0]            data_i,
    output logic [BW-1:0]            data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer wrap relies on DEPTH being a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/iic_dsmod_ctrl.sv
// Front-end controller for the delta-sigma modulator: buffers incoming samples,
// hands one to the modulator on every fetch strobe, and ramps the attenuation
// one step per RAMP_SAMPLES fetches on start, target change and stop, so the
// output never jumps in level.
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   enable_i                1 = play, 0 = stop (ramped)
//   mode_i, osr_i           modulator order / OSR, latched when leaving IDLE
//   scale_i                 target attenuation (0 = 0 dB, 15 = off)
//   clr_i                   clears the sticky underrun flag
//   s_data_i/s_valid_i/s_ready_o   sample stream in
//   dsm_data_o, dsm_rd_i    sample to modulator, modulator fetch strobe
//   dsm_rst_n_o             modulator synchronous reset (low in IDLE)
//   dsm_mode_o, dsm_osr_o, dsm_scale_o   latched config and ramped scale
//   busy_o, underrun_o, fill_o   status
module iic_dsmod_ctrl
    import iic_dsmod_pkg::*;
#(
    parameter int BW           = 16,
    parameter int DEPTH        = 4,
    parameter int RAMP_SAMPLES = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic                   mode_i,
    input  logic [1:0]             osr_i,
    input  logic [3:0]             scale_i,
    input  logic                   clr_i,
    input  logic [BW-1:0]          s_data_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic [BW-1:0]          dsm_data_o,
    input  logic                   dsm_rd_i,
    output logic                   dsm_rst_n_o,
    output logic                   dsm_mode_o,
    output logic [1:0]             dsm_osr_o,
    output logic [3:0]             dsm_scale_o,
    output logic                   busy_o,
    output logic                   underrun_o,
    output logic [$clog2(DEPTH):0] fill_o
);

    localparam logic [BW-1:0] DATA_MID = BW'(data_mid_of(BW));
    localparam int CW = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_SAMPLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    scale_q, scale_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic [1:0]    osr_q, osr_d;
    logic [BW-1:0] data_q, data_d;
    logic          underrun_q, underrun_d;
    logic          rdy_en_q, rdy_en_d;

    logic          active, rd_act, boundary;
    logic          fifo_push, fifo_pop, fifo_flush;
    logic          fifo_full, fifo_empty, underrun_set;
    logic [BW-1:0] fifo_head;

    // Ready stays low during reset and rises on the first clock after release.
    assign rdy_en_d  = 1'b1;
    assign s_ready_o = rdy_en_q && !fifo_full;
    assign fifo_push = s_valid_i && s_ready_o;

    assign active       = (state_q != ST_IDLE);
    assign rd_act       = dsm_rd_i && active;
    assign boundary     = rd_act && (cnt_q == CNT_LAST);
    assign fifo_pop     = rd_act && !fifo_empty;
    assign underrun_set = rd_act && fifo_empty;

    iic_sync_fifo #(
        .BW    (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .data_i  (s_data_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fill_o)
    );

    // Ramp sequencing. The fetch counter keeps running across state changes so
    // a stop or restart mid-step does not shorten or stretch the step. A step
    // that coincides with a state change is skipped; the new state takes the
    // next boundary.
    always_comb begin
        state_d    = state_q;
        scale_d    = scale_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        osr_d      = osr_q;
        fifo_flush = 1'b0;

        if (rd_act) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                scale_d = SCALE_OFF;
                if (enable_i) begin
                    mode_d  = mode_i;
                    osr_d   = osr_i;
                    cnt_d   = '0;
                    state_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                // Entered from RAMP_DOWN the scale may already be at or below
                // target; RUN then walks it the rest of the way.
                if (!enable_i) begin
                    state_d = ST_RAMP_DOWN;
                end else if (scale_q <= scale_i) begin
                    state_d = ST_RUN;
                end else if (boundary) begin
                    scale_d = scale_q - 4'd1;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    state_d = ST_RAMP_DOWN;
                end else if (boundary) begin
                    scale_d = scale_toward(scale_q, scale_i);
                end
            end
            ST_RAMP_DOWN: begin
                if (enable_i) begin
                    state_d = ST_RAMP_UP;
                end else if (scale_q == SCALE_OFF) begin
                    state_d    = ST_IDLE;
                    fifo_flush = 1'b1;
                end else if (boundary) begin
                    scale_d = scale_q + 4'd1;
                    if (scale_d == SCALE_OFF) begin
                        state_d    = ST_IDLE;
                        fifo_flush = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sample register toward the modulator, parked at mid-scale whenever the
    // controller is or is about to be idle.
    always_comb begin
        data_d = data_q;
        if (fifo_pop) begin
            data_d = fifo_head;
        end else if (underrun_set) begin
            data_d = DATA_MID;
        end
        if (state_d == ST_IDLE) begin
            data_d = DATA_MID;
        end
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (clr_i) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            scale_q    <= SCALE_OFF;
            cnt_q      <= '0;
            mode_q     <= MODE_1ST;
            osr_q      <= OSR_32;
            data_q     <= DATA_MID;
            underrun_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            scale_q    <= scale_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            osr_q      <= osr_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    assign dsm_data_o  = data_q;
    assign dsm_rst_n_o = active;
    assign busy_o      = active;
    assign dsm_mode_o  = mode_q;
    assign dsm_osr_o   = osr_q;
    assign dsm_scale_o = scale_q;
    assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_iic_dsmod_ctrl.sv
// Directed self-checking bench for iic_dsmod_ctrl: reset values, IDLE fetch
// rejection, start-up ramp, underrun flag, simultaneous push/pop, target
// tracking, ramped stop with flush, re-enable mid ramp-down, async reset in
// RUN and the muted-target start.
module tb_iic_dsmod_ctrl;

    localparam int BW    = 16;
    localparam int DEPTH = 4;
    localparam int RS    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] osr = 2'd0;
    logic [3:0] scale_tgt = 4'd0;
    logic       clr = 1'b0;

    logic       dsm_mode;
    logic [1:0] dsm_osr;
    logic [3:0] dsm_scale;
    logic       busy;
    logic       underrun;
    logic [$clog2(DEPTH):0] fill;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int ramp_cnt   = 0;

    iic_dsmod_ctrl_if #(.BW(BW)) sif ();

    iic_dsmod_ctrl #(
        .BW           (BW),
        .DEPTH        (DEPTH),
        .RAMP_SAMPLES (RS)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .enable_i    (enable),
        .mode_i      (mode),
        .osr_i       (osr),
        .scale_i     (scale_tgt),
        .clr_i       (clr),
        .s_data_i    (sif.s_data),
        .s_valid_i   (sif.s_valid),
        .s_ready_o   (sif.s_ready),
        .dsm_data_o  (sif.dsm_data),
        .dsm_rd_i    (sif.dsm_rd),
        .dsm_rst_n_o (sif.dsm_rst_n),
        .dsm_mode_o  (dsm_mode),
        .dsm_osr_o   (dsm_osr),
        .dsm_scale_o (dsm_scale),
        .busy_o      (busy),
        .underrun_o  (underrun),
        .fill_o      (fill)
    );

    always #5 clk = ~clk;

    // Guards against a hung sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no end of sequence, expected finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // n modulator fetch strobes, one every 32 clocks; tracks the fetch
    // position within the current ramp step.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) sif.dsm_rd = 1'b1;
            @(negedge clk) sif.dsm_rd = 1'b0;
            ramp_cnt = (ramp_cnt == RS - 1) ? 0 : ramp_cnt + 1;
            repeat (30) @(negedge clk);
        end
    endtask

    // Fetch until n more ramp boundaries have passed.
    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(RS - ramp_cnt);
        end
    endtask

    task automatic push_sample(input logic [BW-1:0] v);
        @(negedge clk);
        sif.s_data  = v;
        sif.s_valid = 1'b1;
        @(negedge clk);
        sif.s_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    initial begin
        sif.s_data  = '0;
        sif.s_valid = 1'b0;
        sif.dsm_rd  = 1'b0;

        // Reset asserted before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(sif.s_ready), 32'd0);
        checkOutput("rst_dsm_rst_n", 32'(sif.dsm_rst_n), 32'd0);
        checkOutput("rst_scale", 32'(dsm_scale), 32'd15);
        checkOutput("rst_data", 32'(sif.dsm_data), 32'h8000);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_fill", 32'(fill), 32'd0);
        checkOutput("rst_mode", 32'(dsm_mode), 32'd0);
        checkOutput("rst_osr", 32'(dsm_osr), 32'd0);

        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 checkOutput("ready_before_clk", 32'(sif.s_ready), 32'd0);
        @(negedge clk);
        checkOutput("ready_after_clk", 32'(sif.s_ready), 32'd1);

        // Prefill to full; a fetch strobe in IDLE must change nothing.
        push_sample(16'h1111);
        push_sample(16'h2222);
        push_sample(16'h3333);
        push_sample(16'h4444);
        checkOutput("prefill_fill", 32'(fill), 32'd4);
        checkOutput("prefill_ready", 32'(sif.s_ready), 32'd0);
        @(negedge clk) sif.dsm_rd = 1'b1;
        @(negedge clk) sif.dsm_rd = 1'b0;
        checkOutput("idle_rd_data", 32'(sif.dsm_data), 32'h8000);
        checkOutput("idle_rd_fill", 32'(fill), 32'd4);
        checkOutput("idle_rd_underrun", 32'(underrun), 32'd0);

        // Start: config latched on leaving IDLE, later changes ignored.
        mode = 1'b1;
        osr = 2'd2;
        scale_tgt = 4'd2;
        enable = 1'b1;
        @(negedge clk);
        ramp_cnt = 0;
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_dsm_rst_n", 32'(sif.dsm_rst_n), 32'd1);
        checkOutput("start_mode", 32'(dsm_mode), 32'd1);
        checkOutput("start_osr", 32'(dsm_osr), 32'd2);
        checkOutput("start_scale", 32'(dsm_scale), 32'd15);
        mode = 1'b0;
        osr = 2'd1;
        @(negedge clk);
        checkOutput("hold_mode", 32'(dsm_mode), 32'd1);
        checkOutput("hold_osr", 32'(dsm_osr), 32'd2);

        // FIFO drains in order, then underruns.
        applyStimulus(1);
        checkOutput("pop1_data", 32'(sif.dsm_data), 32'h1111);
        checkOutput("pop1_fill", 32'(fill), 32'd3);
        applyStimulus(1);
        checkOutput("pop2_data", 32'(sif.dsm_data), 32'h2222);
        applyStimulus(1);
        checkOutput("pop3_data", 32'(sif.dsm_data), 32'h3333);
        applyStimulus(1);
        checkOutput("pop4_data", 32'(sif.dsm_data), 32'h4444);
        checkOutput("pop4_fill", 32'(fill), 32'd0);
        applyStimulus(1);
        checkOutput("ramp_underrun_data", 32'(sif.dsm_data), 32'h8000);
        checkOutput("ramp_underrun_flag", 32'(underrun), 32'd1);
        pulse_clr();
        checkOutput("ramp_underrun_clr", 32'(underrun), 32'd0);

        // Start-up ramp 15 -> 2, one step every 8 fetches.
        applyStimulus(RS - 1 - ramp_cnt);
        checkOutput("ramp_pre_step1", 32'(dsm_scale), 32'd15);
        applyStimulus(1);
        checkOutput("ramp_step1", 32'(dsm_scale), 32'd14);
        for (int k = 2; k <= 13; k++) begin
            applyStimulus(RS - 1);
            checkOutput("ramp_pre_step", 32'(dsm_scale), 32'(16 - k));
            applyStimulus(1);
            checkOutput("ramp_step", 32'(dsm_scale), 32'(15 - k));
        end
        run_steps(1);
        checkOutput("run_hold_scale", 32'(dsm_scale), 32'd2);
        checkOutput("run_busy", 32'(busy), 32'd1);

        // Underrun in RUN: sticky, set wins over a simultaneous clear.
        pulse_clr();
        checkOutput("run_underrun_clr0", 32'(underrun), 32'd0);
        applyStimulus(1);
        checkOutput("run_underrun_set", 32'(underrun), 32'd1);
        checkOutput("run_underrun_data", 32'(sif.dsm_data), 32'h8000);
        applyStimulus(1);
        checkOutput("run_underrun_sticky", 32'(underrun), 32'd1);
        @(negedge clk);
        clr = 1'b1;
        sif.dsm_rd = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        sif.dsm_rd = 1'b0;
        ramp_cnt = (ramp_cnt == RS - 1) ? 0 : ramp_cnt + 1;
        checkOutput("underrun_set_prio", 32'(underrun), 32'd1);
        pulse_clr();
        checkOutput("underrun_clr", 32'(underrun), 32'd0);

        // Simultaneous push and pop at fill 2.
        push_sample(16'h1234);
        push_sample(16'h5678);
        checkOutput("pp_fill_before", 32'(fill), 32'd2);
        @(negedge clk);
        sif.s_data  = 16'h9ABC;
        sif.s_valid = 1'b1;
        sif.dsm_rd  = 1'b1;
        @(negedge clk);
        sif.s_valid = 1'b0;
        sif.dsm_rd  = 1'b0;
        ramp_cnt = (ramp_cnt == RS - 1) ? 0 : ramp_cnt + 1;
        checkOutput("pp_data", 32'(sif.dsm_data), 32'h1234);
        checkOutput("pp_fill", 32'(fill), 32'd2);
        applyStimulus(1);
        checkOutput("pp_next_data", 32'(sif.dsm_data), 32'h5678);
        checkOutput("pp_next_fill", 32'(fill), 32'd1);
        applyStimulus(1);
        checkOutput("pp_last_data", 32'(sif.dsm_data), 32'h9ABC);
        checkOutput("pp_last_fill", 32'(fill), 32'd0);

        // Target raised in RUN: single steps 2 -> 5, then held.
        scale_tgt = 4'd5;
        run_steps(1);
        checkOutput("track_3", 32'(dsm_scale), 32'd3);
        run_steps(1);
        checkOutput("track_4", 32'(dsm_scale), 32'd4);
        run_steps(1);
        checkOutput("track_5", 32'(dsm_scale), 32'd5);
        run_steps(1);
        checkOutput("track_hold", 32'(dsm_scale), 32'd5);

        // Stop at 5: ten steps to off, then IDLE with the FIFO flushed.
        enable = 1'b0;
        @(negedge clk);
        checkOutput("stop_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            run_steps(1);
            checkOutput("down_step", 32'(dsm_scale), 32'(5 + k));
        end
        checkOutput("down_dsm_rst_n", 32'(sif.dsm_rst_n), 32'd1);
        applyStimulus(RS - 1);
        checkOutput("down_pre_last", 32'(dsm_scale), 32'd14);
        push_sample(16'hAAAA);
        push_sample(16'hBBBB);
        push_sample(16'hCCCC);
        checkOutput("down_fill", 32'(fill), 32'd3);
        applyStimulus(1);
        checkOutput("off_scale", 32'(dsm_scale), 32'd15);
        checkOutput("off_busy", 32'(busy), 32'd0);
        checkOutput("off_dsm_rst_n", 32'(sif.dsm_rst_n), 32'd0);
        checkOutput("off_fill", 32'(fill), 32'd0);
        checkOutput("off_data", 32'(sif.dsm_data), 32'h8000);

        // Re-enable during ramp-down at 9 with target 0.
        pulse_clr();
        mode = 1'b0;
        osr = 2'd3;
        scale_tgt = 4'd7;
        enable = 1'b1;
        @(negedge clk);
        ramp_cnt = 0;
        checkOutput("re_mode", 32'(dsm_mode), 32'd0);
        checkOutput("re_osr", 32'(dsm_osr), 32'd3);
        run_steps(8);
        checkOutput("re_at_7", 32'(dsm_scale), 32'd7);
        enable = 1'b0;
        @(negedge clk);
        run_steps(2);
        checkOutput("re_down_9", 32'(dsm_scale), 32'd9);
        scale_tgt = 4'd0;
        enable = 1'b1;
        @(negedge clk);
        checkOutput("re_enable_scale", 32'(dsm_scale), 32'd9);
        checkOutput("re_enable_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(RS - 1 - ramp_cnt);
            checkOutput("re_pre_step", 32'(dsm_scale), 32'(10 - k));
            applyStimulus(1);
            checkOutput("re_step", 32'(dsm_scale), 32'(9 - k));
        end

        // Async reset in RUN, between clock edges.
        push_sample(16'h0101);
        push_sample(16'h0202);
        checkOutput("pre_rst_fill", 32'(fill), 32'd2);
        checkOutput("pre_rst_underrun", 32'(underrun), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_dsm_rst_n", 32'(sif.dsm_rst_n), 32'd0);
        checkOutput("arst_scale", 32'(dsm_scale), 32'd15);
        checkOutput("arst_data", 32'(sif.dsm_data), 32'h8000);
        checkOutput("arst_fill", 32'(fill), 32'd0);
        checkOutput("arst_ready", 32'(sif.s_ready), 32'd0);
        checkOutput("arst_underrun", 32'(underrun), 32'd0);
        checkOutput("arst_mode", 32'(dsm_mode), 32'd0);
        checkOutput("arst_osr", 32'(dsm_osr), 32'd0);
        enable = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(sif.s_ready), 32'd1);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_fill", 32'(fill), 32'd0);

        // Muted target: RUN with the scale held at off.
        scale_tgt = 4'd15;
        enable = 1'b1;
        @(negedge clk);
        ramp_cnt = 0;
        checkOutput("mute_busy", 32'(busy), 32'd1);
        run_steps(1);
        checkOutput("mute_scale", 32'(dsm_scale), 32'd15);
        checkOutput("mute_dsm_rst_n", 32'(sif.dsm_rst_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
